sram_req_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arb_pick.sv | 39 +++
 rtl/sram_req_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and defaults for the SRAM request arbiter
//
// Purpose : FSM state encodings, requester port ids and the default
//           timeout length shared by sram_req_arbiter and sram_arb_pick.
// Ports   : none (package).

package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   localparam int TMO_CYC_DEF = 16;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner select for the SRAM arbiter
//
// Purpose : Chooses which requester gets the next grant out of IDLE.
//           Macro SRAM_ARB_RR_EN: round-robin on simultaneous requests
//           (the port that was not granted last wins). Without it, fixed
//           priority with port A (pipeline) always winning.
// Ports   : last  - port granted most recently (round-robin build only)
//           a_req - port A has a read or write pending
//           b_req - port B has a read or write pending
//           win   - selected port; only meaningful when a request is pending

import sram_arb_pkg::*;

module sram_arb_pick (
`ifdef SRAM_ARB_RR_EN
   input  port_t last,
`endif
   input  logic  a_req,
   input  logic  b_req,
   output port_t win
);

`ifdef SRAM_ARB_RR_EN
   always_comb begin
      win = PORT_A;
      if (a_req && b_req)
         win = (last == PORT_A) ? PORT_B : PORT_A;
      else if (b_req)
         win = PORT_B;
   end
`else
   always_comb begin
      win = PORT_A;
      if (!a_req && b_req)
         win = PORT_B;
   end
`endif

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-port arbiter in front of the SRAM controller
//
// Purpose : Shares the single SRAM controller request interface between
//           port A (pipeline MEM stage) and port B (loader/DMA). The grant
//           is held until mem_ready, then a one-cycle GAP with enables low
//           returns the registered ready pulse and lets the controller
//           settle in IDLE. Macro SRAM_ARB_RR_EN selects round-robin
//           arbitration (see sram_arb_pick); default is fixed priority A.
// Ports   : clk, rst                    clock, async active-high reset
//           a_rd_en, a_wr_en            port A read / write request (held to a_ready)
//           a_addr, a_wdata             port A address / write data
//           a_rdata, a_ready            port A registered read data / 1-cycle done
//           b_*                         same as a_* for port B
//           mem_rd_en, mem_wr_en        controller enables (GRANT only)
//           mem_addr, mem_wdata         controller address / write data (0 outside GRANT)
//           mem_rdata, mem_ready        controller read data / completion
//           timeout_err                 sticky, set after TMO_CYC GRANT cycles without mem_ready

import sram_arb_pkg::*;

module sram_req_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_rd_en,
   input  logic              a_wr_en,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_ready,
   input  logic              b_rd_en,
   input  logic              b_wr_en,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_ready,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TMO_CYC + 1);

   arb_state_t       state, state_nxt;
   port_t            grant, win;
   logic             a_req, b_req;
   logic             a_rd, a_wr, b_rd, b_wr;
   logic [CNT_W-1:0] tmo_cnt;

   // A simultaneous read+write is treated as a write only.
   assign a_wr  = a_wr_en;
   assign a_rd  = a_rd_en & ~a_wr_en;
   assign b_wr  = b_wr_en;
   assign b_rd  = b_rd_en & ~b_wr_en;
   assign a_req = a_rd_en | a_wr_en;
   assign b_req = b_rd_en | b_wr_en;

`ifdef SRAM_ARB_RR_EN
   port_t last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= PORT_B;
      else if (state == ST_IDLE && (a_req || b_req))
         last <= win;
   end
`endif

   sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
      .last  (last),
`endif
      .a_req (a_req),
      .b_req (b_req),
      .win   (win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Enables follow the granted port live, so a requester that drops its
   // request mid-GRANT sees the enables fall while the FSM keeps waiting.
   always_comb begin
      state_nxt = state;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ST_IDLE: begin
            if (a_req || b_req)
               state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (grant == PORT_A) begin
               mem_rd_en = a_rd;
               mem_wr_en = a_wr;
               mem_addr  = a_addr;
               mem_wdata = a_wdata;
            end else begin
               mem_rd_en = b_rd;
               mem_wr_en = b_wr;
               mem_addr  = b_addr;
               mem_wdata = b_wdata;
            end
            if (mem_ready)
               state_nxt = ST_GAP;
         end
         ST_GAP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         grant <= PORT_A;
      else if (state == ST_IDLE && (a_req || b_req))
         grant <= win;
   end

   // Ready is registered off the completion edge, so it is high exactly
   // during GAP; read data is captured on that same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_ready <= 1'b0;
         b_ready <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         a_ready <= 1'b0;
         b_ready <= 1'b0;
         if (state == ST_GRANT && mem_ready) begin
            if (grant == PORT_A) begin
               a_ready <= 1'b1;
               if (mem_rd_en)
                  a_rdata <= mem_rdata;
            end else begin
               b_ready <= 1'b1;
               if (mem_rd_en)
                  b_rdata <= mem_rdata;
            end
         end
      end
   end

   // Counter restarts on every GRANT entry; the error flag only reports,
   // the FSM still waits for mem_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else if (state != ST_GRANT) begin
         tmo_cnt <= '0;
      end else if (!mem_ready) begin
         if (tmo_cnt != CNT_W'(TMO_CYC))
            tmo_cnt <= tmo_cnt + 1'b1;
         if (tmo_cnt == CNT_W'(TMO_CYC - 1))
            timeout_err <= 1'b1;
      end
   end

endmodule
